// File: rtl/sbox_share_ctrl.sv
// Arbitrates NREQ requesters onto one shared masked S-box instance: round-robin grant,
// one operation in flight, Synch-or-watchdog completion, held response until accepted.
module sbox_share_ctrl #(
  parameter  int NREQ    = 4,
  parameter  int SHARES  = 5,
  parameter  int TIMEOUT = 16,
  localparam int W       = 4 * SHARES,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_data,
  output logic [W-1:0]        sb_in,
  input  logic [W-1:0]        sb_out,
  output logic                sb_rst,
  input  logic                sb_synch,
  output logic                fresh_en,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W-1:0]        rsp_data,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_err,
  output logic                busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic [CW-1:0]  cnt_reg;
  logic [W-1:0]   in_reg;
  logic [IDW-1:0] id_reg;
  logic [W-1:0]   rsp_data_reg;
  logic           rsp_err_reg;

  logic [W-1:0]    slices [NREQ];
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win;
  logic            found;
  logic            timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slices[gi] = req_data[gi*W +: W];
    end
  endgenerate

  // Round-robin search starting at ptr_reg, wrapping past NREQ-1 back to 0.
  always_comb begin
    logic [IDW:0] pos;
    grant = '0;
    win   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr_reg} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NREQ)) begin
        pos = pos - (IDW+1)'(NREQ);
      end
      if (!found && req_valid[pos[IDW-1:0]]) begin
        found = 1'b1;
        win   = pos[IDW-1:0];
      end
    end
    if (found) begin
      grant[win] = 1'b1;
    end
  end

  // Grant is visible only while idle and out of reset.
  assign req_ready   = (state_reg == IDLE && rst) ? grant : '0;
  assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));
  assign ptr_next    = (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + IDW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sb_rst     = 1'b1;
    fresh_en   = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    sb_in      = '0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (found) begin
          state_next = RUN;
        end
      end
      RUN: begin
        sb_rst   = 1'b0;
        fresh_en = 1'b1;
        sb_in    = in_reg;
        if (sb_synch || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      in_reg       <= '0;
      id_reg       <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            in_reg  <= slices[win];
            id_reg  <= win;
            cnt_reg <= '0;
          end
        end
        RUN: begin
          if (cnt_reg != CW'(TIMEOUT)) begin
            cnt_reg <= cnt_reg + CW'(1);
          end
          // Synch wins over a watchdog expiry landing on the same cycle.
          if (sb_synch) begin
            rsp_data_reg <= sb_out;
            rsp_err_reg  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data_reg <= sb_out;
            rsp_err_reg  <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            ptr_reg <= ptr_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_data = rsp_data_reg;
  assign rsp_id   = id_reg;
  assign rsp_err  = rsp_err_reg;

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl: vector table of arbitration/latency cases plus
// a hand-written mid-RUN reset sequence, against a behavioural masked PRESENT S-box.
module tb_sbox_share_ctrl;
  localparam int NREQ = 4, SHARES = 5, TIMEOUT = 16, W = 4 * SHARES, IDW = 2;
  localparam int SYNCH_LAT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_data = '0;
  logic [W-1:0]      sb_in, sb_out, rsp_data;
  logic              sb_rst, sb_synch, fresh_en, rsp_valid, rsp_err, busy;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;

  int   checks = 0;
  int   failures = 0;
  logic synch_en = 1'b1;
  int   sbox_cnt = 0;

  sbox_share_ctrl #(.NREQ(NREQ), .SHARES(SHARES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .sb_in(sb_in), .sb_out(sb_out), .sb_rst(sb_rst),
    .sb_synch(sb_synch), .fresh_en(fresh_en), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] present_s(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h2174_8FE3_DA09_B65C;
    return t[x*4 +: 4];
  endfunction

  function automatic logic [3:0] recomb(input logic [W-1:0] v);
    logic [3:0] r;
    r = '0;
    for (int j = 0; j < SHARES; j++) r = r ^ v[j*4 +: 4];
    return r;
  endfunction

  // Output shares 1..4 copy the input shares; share 0 absorbs S(x) so recombination yields S(x).
  function automatic logic [W-1:0] sbox_model(input logic [W-1:0] v);
    logic [W-1:0] o;
    o = v;
    o[3:0] = present_s(recomb(v)) ^ recomb(v) ^ v[3:0];
    return o;
  endfunction

  function automatic logic [W-1:0] mix(input int seed, input int i);
    logic [31:0] x;
    x = 32'(seed) * 32'h9E37_79B1 + 32'(i) * 32'h7F4A_7C15;
    x = x ^ (x >> 13);
    return x[W-1:0];
  endfunction

  // S-box model: counts cycles out of sb_rst, raises Synch after SYNCH_LAT of them.
  always @(posedge clk) begin
    if (sb_rst) sbox_cnt <= 0;
    else        sbox_cnt <= sbox_cnt + 1;
  end
  assign sb_synch = synch_en && !sb_rst && (sbox_cnt == SYNCH_LAT);
  assign sb_out   = sbox_model(sb_in);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_data(input int seed);
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = mix(seed, i);
  endtask

  typedef struct {
    logic [3:0]     valid;
    int             seed;
    logic           synch;
    logic           drop;
    logic [IDW-1:0] exp_id;
    logic           exp_err;
    int             exp_lat;
    int             bp;
  } vec_t;

  task automatic run_vec(input vec_t v, input int n);
    logic [3:0]   exp_g;
    logic [W-1:0] granted, exp_out;
    logic [23:0]  snap;
    int           lat, runs;
    synch_en  = v.synch;
    rsp_ready = (v.bp == 0);
    req_valid = v.valid;
    set_data(v.seed);
    #1;
    exp_g = 4'b0001 << v.exp_id;
    chk($sformatf("v%0d_grant", n), 32'(req_ready), 32'(exp_g));
    granted = req_data[v.exp_id*W +: W];
    exp_out = sbox_model(granted);
    lat = 0;
    runs = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (v.drop) req_valid = '0;
      #1;
      if (!rsp_valid) begin
        runs++;
        chk($sformatf("v%0d_run_iso", n), {5'b0, sb_in, fresh_en, sb_rst, req_ready, busy},
            {5'b0, granted, 1'b1, 1'b0, 4'b0000, 1'b1});
      end
    end while (!rsp_valid && lat < 40);
    $display("vec %0d: id=%0d err=%0b latency=%0d run_cycles=%0d data=%05h", n, rsp_id, rsp_err, lat, runs, rsp_data);
    chk($sformatf("v%0d_rsp_valid", n), 32'(rsp_valid), 32'd1);
    chk($sformatf("v%0d_latency", n), lat, v.exp_lat);
    chk($sformatf("v%0d_run_cycles", n), runs, v.exp_lat - 1);
    chk($sformatf("v%0d_rsp_id", n), 32'(rsp_id), 32'(v.exp_id));
    chk($sformatf("v%0d_rsp_err", n), 32'(rsp_err), 32'(v.exp_err));
    chk($sformatf("v%0d_rsp_data", n), 32'(rsp_data), 32'(exp_out));
    chk($sformatf("v%0d_recomb", n), 32'(recomb(rsp_data)), 32'(present_s(recomb(granted))));
    chk($sformatf("v%0d_done_iso", n), {sb_in, fresh_en, sb_rst, req_ready, busy},
        {20'h0, 1'b0, 1'b1, 4'b0000, 1'b1});
    snap = {rsp_valid, rsp_err, rsp_id, rsp_data};
    for (int b = 0; b < v.bp; b++) begin
      @(posedge clk); #1;
      chk($sformatf("v%0d_bp_hold%0d", n, b), 32'({rsp_valid, rsp_err, rsp_id, rsp_data}), 32'(snap));
      chk($sformatf("v%0d_bp_busy%0d", n, b), {req_ready, busy, sb_in, fresh_en}, {4'b0000, 1'b1, 20'h0, 1'b0});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle", n), {busy, rsp_valid, fresh_en, sb_rst, sb_in},
        {1'b0, 1'b0, 1'b0, 1'b1, 20'h0});
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{4'b0100,  1, 1'b1, 1'b1, 2'd2, 1'b0, 10, 0};
    vecs[1]  = '{4'b1111,  2, 1'b1, 1'b0, 2'd3, 1'b0, 10, 0};
    vecs[2]  = '{4'b1111,  3, 1'b1, 1'b0, 2'd0, 1'b0, 10, 0};
    vecs[3]  = '{4'b1111,  4, 1'b1, 1'b0, 2'd1, 1'b0, 10, 0};
    vecs[4]  = '{4'b1111,  5, 1'b1, 1'b0, 2'd2, 1'b0, 10, 0};
    vecs[5]  = '{4'b1111,  6, 1'b1, 1'b0, 2'd3, 1'b0, 10, 0};
    vecs[6]  = '{4'b1111,  7, 1'b1, 1'b0, 2'd0, 1'b0, 10, 0};
    vecs[7]  = '{4'b0001,  8, 1'b1, 1'b0, 2'd0, 1'b0, 10, 0};
    vecs[8]  = '{4'b1001,  9, 1'b1, 1'b0, 2'd3, 1'b0, 10, 0};
    vecs[9]  = '{4'b0010, 10, 1'b0, 1'b0, 2'd1, 1'b1, 17, 0};
    vecs[10] = '{4'b0010, 11, 1'b1, 1'b0, 2'd1, 1'b0, 10, 0};
    vecs[11] = '{4'b1111, 12, 1'b1, 1'b0, 2'd2, 1'b0, 10, 5};

    // Reset state, with requests pending that must not be granted.
    req_valid = 4'b1111;
    set_data(99);
    #1;
    chk("reset_outputs", {1'b0, req_ready, sb_in, sb_rst, fresh_en, rsp_valid, rsp_err, rsp_id, busy},
        {1'b0, 4'b0000, 20'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0});
    chk("reset_rsp_data", 32'(rsp_data), 32'h0);
    repeat (2) @(posedge clk);
    #2;
    chk("reset_held_busy", {req_ready, busy}, {4'b0000, 1'b0});
    req_valid = '0;
    rst = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset during the third RUN cycle: operation aborted, arbitration restarts at 0.
    synch_en = 1'b1;
    req_valid = 4'b1000;
    set_data(20);
    #1;
    chk("rr_grant", 32'(req_ready), 32'(4'b1000));
    repeat (3) @(posedge clk);
    #1;
    chk("rr_in_run", {busy, fresh_en}, {1'b1, 1'b1});
    rst = 1'b0;
    #1;
    chk("rr_outputs", {1'b0, req_ready, sb_in, sb_rst, fresh_en, rsp_valid, rsp_err, rsp_id, busy},
        {1'b0, 4'b0000, 20'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0});
    chk("rr_rsp_data", 32'(rsp_data), 32'h0);
    $display("reset mid-RUN: busy=%0b rsp_valid=%0b sb_in=%05h", busy, rsp_valid, sb_in);
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rr_no_grant_in_reset", {req_ready, busy, rsp_valid}, {4'b0000, 1'b0, 1'b0});
    rst = 1'b1;
    run_vec('{4'b1111, 13, 1'b1, 1'b0, 2'd0, 1'b0, 10, 0}, 12);
    run_vec('{4'b1111, 14, 1'b1, 1'b0, 2'd1, 1'b0, 10, 0}, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
